// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: aligns stores, formats loads, and runs a
// variable-latency req/ack handshake to the data cache with flush support.
module mem_lsu #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned ADDR_W = 32,
    localparam int unsigned LANES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_valid,
    input  logic              MEM_allow_in,
    input  logic              MEM_cancel,
    input  logic [4:0]        mem_op,
    input  logic [ADDR_W-1:0] exe_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        rf_wdest,
    output logic              dm_req,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [LANES-1:0]  dm_wen,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              MEM_over,
    output logic [DATA_W-1:0] MEM_result,
    output logic [4:0]        MEM_wdest,
    output logic              adel,
    output logic              ades
);

    localparam int unsigned OFF_W = $clog2(LANES);
    localparam int unsigned SH_W  = OFF_W + 3;
    localparam bit          IS64  = (DATA_W == 64);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e            state_q, state_d;
    logic              cancelled_q, cancelled_d;
    logic              dm_req_q, dm_req_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [LANES-1:0]  dm_wen_q, dm_wen_d;
    logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic              load_q, load_d;
    logic [OFF_W-1:0]  off_q, off_d;

    logic              inst_load, inst_store, ld_sign, memop, misaligned;
    logic [1:0]        size;
    logic [OFF_W-1:0]  off;
    logic [SH_W-1:0]   st_sh, ld_sh;
    logic [LANES-1:0]  wen_mask, req_wen;
    logic [DATA_W-1:0] req_wdata, ld_raw, ld_fmt;
    logic              mem_over_c;

    assign inst_load  = mem_op[4];
    assign inst_store = mem_op[3];
    assign size       = mem_op[2:1];
    assign ld_sign    = mem_op[0];
    assign memop      = inst_load | inst_store;
    assign off        = exe_result[OFF_W-1:0];

    // Dword accesses are always illegal on a 32-bit bus.
    always_comb begin
        misaligned = 1'b0;
        unique case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = |off[1:0];
            default: misaligned = !IS64 || (off != '0);
        endcase
    end

    // Store lane alignment
    always_comb begin
        wen_mask = '0;
        unique case (size)
            2'd0:    wen_mask = LANES'(8'h01);
            2'd1:    wen_mask = LANES'(8'h03);
            2'd2:    wen_mask = LANES'(8'h0F);
            default: wen_mask = LANES'(8'hFF);
        endcase
    end

    assign st_sh     = {off, 3'b000};
    assign req_wen   = inst_store ? (wen_mask << off) : '0;
    assign req_wdata = store_data << st_sh;

    // Load formatting uses the access parameters captured at request time.
    assign ld_sh  = {off_q, 3'b000};
    assign ld_raw = dm_rdata >> ld_sh;

    always_comb begin
        ld_fmt = ld_raw;
        unique case (size_q)
            2'd0:    ld_fmt = sign_q ? DATA_W'($signed(ld_raw[7:0]))  : DATA_W'(ld_raw[7:0]);
            2'd1:    ld_fmt = sign_q ? DATA_W'($signed(ld_raw[15:0])) : DATA_W'(ld_raw[15:0]);
            2'd2:    ld_fmt = sign_q ? DATA_W'($signed(ld_raw[31:0])) : DATA_W'(ld_raw[31:0]);
            default: ld_fmt = ld_raw;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cancelled_q <= 1'b0;
            dm_req_q    <= 1'b0;
            dm_addr_q   <= '0;
            dm_wen_q    <= '0;
            dm_wdata_q  <= '0;
            result_q    <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            load_q      <= 1'b0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            cancelled_q <= cancelled_d;
            dm_req_q    <= dm_req_d;
            dm_addr_q   <= dm_addr_d;
            dm_wen_q    <= dm_wen_d;
            dm_wdata_q  <= dm_wdata_d;
            result_q    <= result_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            load_q      <= load_d;
            off_q       <= off_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cancelled_d = cancelled_q;
        dm_req_d    = dm_req_q;
        dm_addr_d   = dm_addr_q;
        dm_wen_d    = dm_wen_q;
        dm_wdata_d  = dm_wdata_q;
        result_d    = result_q;
        size_d      = size_q;
        sign_d      = sign_q;
        load_d      = load_q;
        off_d       = off_q;
        mem_over_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mem_over_c = MEM_valid & (!memop | misaligned);
                if (MEM_valid && memop && !misaligned && !MEM_cancel) begin
                    state_d     = S_WAIT;
                    cancelled_d = 1'b0;
                    dm_req_d    = 1'b1;
                    dm_addr_d   = {exe_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    dm_wen_d    = req_wen;
                    dm_wdata_d  = req_wdata;
                    size_d      = size;
                    sign_d      = ld_sign;
                    load_d      = inst_load;
                    off_d       = off;
                end
            end
            S_WAIT: begin
                if (MEM_cancel) cancelled_d = 1'b1;
                // A flushed access still completes on the bus, but its result is dropped.
                if (dm_ack) begin
                    dm_req_d    = 1'b0;
                    cancelled_d = 1'b0;
                    if (cancelled_q || MEM_cancel) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DONE;
                        result_d = load_q ? ld_fmt : DATA_W'(exe_result);
                    end
                end
            end
            S_DONE: begin
                mem_over_c = 1'b1;
                if (MEM_allow_in || MEM_cancel) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dm_req     = dm_req_q;
    assign dm_addr    = dm_addr_q;
    assign dm_wen     = dm_wen_q;
    assign dm_wdata   = dm_wdata_q;
    assign MEM_over   = !reset & mem_over_c;
    assign MEM_result = (state_q == S_DONE) ? result_q : DATA_W'(exe_result);
    assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
    assign adel       = !reset & MEM_valid & inst_load & misaligned;
    assign ades       = !reset & MEM_valid & inst_store & misaligned;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a 32-bit and a 64-bit instance on a shared clock.
module tb_mem_lsu;

    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_LB  = 5'b10001;
    localparam logic [4:0] OP_LHU = 5'b10010;
    localparam logic [4:0] OP_LW  = 5'b10101;
    localparam logic [4:0] OP_LWU = 5'b10100;
    localparam logic [4:0] OP_LD  = 5'b10110;
    localparam logic [4:0] OP_SB  = 5'b01000;
    localparam logic [4:0] OP_SH  = 5'b01010;
    localparam logic [4:0] OP_SW  = 5'b01100;

    logic clk, reset;
    int   n_vec, n_err;

    logic        a_valid, a_allow, a_cancel, a_ack;
    logic [4:0]  a_op, a_wdest, a_wd;
    logic [31:0] a_addr, a_sdata, a_rdata, a_dmaddr, a_wdata, a_res;
    logic [3:0]  a_wen;
    logic        a_req, a_over, a_adel, a_ades;

    logic        b_valid, b_allow, b_cancel, b_ack;
    logic [4:0]  b_op, b_wdest, b_wd;
    logic [31:0] b_addr, b_dmaddr;
    logic [63:0] b_sdata, b_rdata, b_wdata, b_res;
    logic [7:0]  b_wen;
    logic        b_req, b_over, b_adel, b_ades;

    mem_lsu #(.DATA_W(32), .ADDR_W(32)) dut32 (
        .clk(clk), .reset(reset), .MEM_valid(a_valid), .MEM_allow_in(a_allow),
        .MEM_cancel(a_cancel), .mem_op(a_op), .exe_result(a_addr), .store_data(a_sdata),
        .rf_wdest(a_wdest), .dm_req(a_req), .dm_addr(a_dmaddr), .dm_wen(a_wen),
        .dm_wdata(a_wdata), .dm_ack(a_ack), .dm_rdata(a_rdata), .MEM_over(a_over),
        .MEM_result(a_res), .MEM_wdest(a_wd), .adel(a_adel), .ades(a_ades)
    );

    mem_lsu #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .reset(reset), .MEM_valid(b_valid), .MEM_allow_in(b_allow),
        .MEM_cancel(b_cancel), .mem_op(b_op), .exe_result(b_addr), .store_data(b_sdata),
        .rf_wdest(b_wdest), .dm_req(b_req), .dm_addr(b_dmaddr), .dm_wen(b_wen),
        .dm_wdata(b_wdata), .dm_ack(b_ack), .dm_rdata(b_rdata), .MEM_over(b_over),
        .MEM_result(b_res), .MEM_wdest(b_wd), .adel(b_adel), .ades(b_ades)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1;
        a_valid = 1'b1; a_allow = 1'b1; a_cancel = 1'b0; a_ack = 1'b0;
        a_op = OP_LW; a_addr = 32'h3001; a_sdata = '0; a_rdata = '0; a_wdest = 5'd0;
        b_valid = 1'b0; b_allow = 1'b1; b_cancel = 1'b0; b_ack = 1'b0;
        b_op = OP_ALU; b_addr = '0; b_sdata = '0; b_rdata = '0; b_wdest = 5'd0;

        // Reset state; misaligned load presented to show over/adel gating
        step(); step();
        chk("rst_req",    64'(a_req),    64'h0);
        chk("rst_addr",   64'(a_dmaddr), 64'h0);
        chk("rst_wen",    64'(a_wen),    64'h0);
        chk("rst_wdata",  64'(a_wdata),  64'h0);
        chk("rst_over",   64'(a_over),   64'h0);
        chk("rst_adel",   64'(a_adel),   64'h0);
        chk("rst_req64",  64'(b_req),    64'h0);
        @(negedge clk);
        reset = 1'b0; a_valid = 1'b0;
        step();

        // LB 0x1003, sign-extended, ack tied high
        a_valid = 1'b1; a_op = OP_LB; a_addr = 32'h1003; a_rdata = 32'h80FF1122;
        a_ack = 1'b1; a_wdest = 5'd7;
        #1;
        chk("lb_arrive_over", 64'(a_over), 64'h0);
        chk("lb_wdest",       64'(a_wd),   64'h7);
        step();
        chk("lb_req",   64'(a_req),    64'h1);
        chk("lb_addr",  64'(a_dmaddr), 64'h1000);
        chk("lb_wen",   64'(a_wen),    64'h0);
        chk("lb_wait_over", 64'(a_over), 64'h0);
        step();
        chk("lb_over",   64'(a_over), 64'h1);
        chk("lb_result", 64'(a_res),  64'hFFFFFF80);
        chk("lb_req_drop", 64'(a_req), 64'h0);
        // Stall in DONE: result must come from the register
        a_allow = 1'b0; a_rdata = 32'h0; a_addr = 32'h9999;
        step(); step();
        chk("hold_over",   64'(a_over), 64'h1);
        chk("hold_result", 64'(a_res),  64'hFFFFFF80);
        a_allow = 1'b1;
        step();

        // SH 0xABCD1234 at 0x2002, then LHU of the same halfword
        a_op = OP_SH; a_addr = 32'h2002; a_sdata = 32'hABCD1234;
        step();
        chk("sh_wen",   64'(a_wen),    64'hC);
        chk("sh_wdata", 64'(a_wdata),  64'h12340000);
        chk("sh_addr",  64'(a_dmaddr), 64'h2000);
        step();
        chk("sh_over", 64'(a_over), 64'h1);
        step();
        a_op = OP_LHU; a_rdata = 32'h12340000;
        step();
        chk("lhu_wen", 64'(a_wen), 64'h0);
        step();
        chk("lhu_result", 64'(a_res),  64'h00001234);
        chk("lhu_over",   64'(a_over), 64'h1);
        step();

        // Misaligned accesses complete immediately with an address error
        a_op = OP_LW; a_addr = 32'h3001;
        #1;
        chk("lw_mis_over",   64'(a_over), 64'h1);
        chk("lw_mis_adel",   64'(a_adel), 64'h1);
        chk("lw_mis_ades",   64'(a_ades), 64'h0);
        chk("lw_mis_result", 64'(a_res),  64'h3001);
        step();
        chk("lw_mis_noreq", 64'(a_req), 64'h0);
        a_op = OP_SW; a_addr = 32'h3002;
        #1;
        chk("sw_mis_ades", 64'(a_ades), 64'h1);
        chk("sw_mis_adel", 64'(a_adel), 64'h0);
        a_op = OP_LD; a_addr = 32'h0000_0008;
        #1;
        chk("ld32_adel", 64'(a_adel), 64'h1);
        step();
        chk("ld32_noreq", 64'(a_req), 64'h0);

        // SW with delayed ack: request stays stable while waiting
        a_op = OP_SW; a_addr = 32'h4004; a_sdata = 32'hDEADBEEF; a_ack = 1'b0;
        step();
        chk("sw_wen", 64'(a_wen), 64'hF);
        for (int i = 0; i < 5; i++) begin
            chk("sw_wait_req",   64'(a_req),    64'h1);
            chk("sw_wait_addr",  64'(a_dmaddr), 64'h4004);
            chk("sw_wait_wdata", 64'(a_wdata),  64'hDEADBEEF);
            chk("sw_wait_over",  64'(a_over),   64'h0);
            step();
        end
        a_ack = 1'b1;
        #1;
        chk("sw_ack_req", 64'(a_req), 64'h1);
        step();
        chk("sw_over",     64'(a_over), 64'h1);
        chk("sw_req_drop", 64'(a_req),  64'h0);
        step();

        // Cancel during WAIT, ack three cycles later
        a_op = OP_LW; a_addr = 32'h5000; a_rdata = 32'h11111111; a_ack = 1'b0;
        step();
        a_cancel = 1'b1;
        #1;
        chk("cxl_over0", 64'(a_over), 64'h0);
        step();
        a_cancel = 1'b0; a_valid = 1'b0;
        chk("cxl_req_held", 64'(a_req),  64'h1);
        chk("cxl_over1",    64'(a_over), 64'h0);
        step();
        chk("cxl_over2", 64'(a_over), 64'h0);
        step();
        a_ack = 1'b1;
        #1;
        chk("cxl_over3", 64'(a_over), 64'h0);
        step();
        chk("cxl_no_over", 64'(a_over), 64'h0);
        a_valid = 1'b1; a_op = OP_ALU; a_addr = 32'h12345678;
        #1;
        chk("add_over",   64'(a_over), 64'h1);
        chk("add_result", 64'(a_res),  64'h12345678);
        chk("add_noreq",  64'(a_req),  64'h0);
        step();
        chk("add_noreq2", 64'(a_req), 64'h0);

        // Ack and cancel in the same WAIT cycle
        a_op = OP_LB; a_addr = 32'h6001; a_ack = 1'b0;
        step();
        a_ack = 1'b1; a_cancel = 1'b1;
        step();
        a_cancel = 1'b0; a_valid = 1'b0;
        #1;
        chk("ackcxl_over", 64'(a_over), 64'h0);
        chk("ackcxl_req",  64'(a_req),  64'h0);
        a_valid = 1'b1; a_op = OP_ALU; a_addr = 32'h77;
        #1;
        chk("ackcxl_idle", 64'(a_over), 64'h1);
        step();

        // Asynchronous reset while waiting for ack
        a_op = OP_LW; a_addr = 32'h7000; a_ack = 1'b0;
        step();
        chk("rstw_req", 64'(a_req), 64'h1);
        reset = 1'b1;
        #1;
        chk("rstw_req_drop", 64'(a_req),  64'h0);
        chk("rstw_over",     64'(a_over), 64'h0);
        reset = 1'b0; a_op = OP_ALU; a_addr = 32'h88;
        #1;
        chk("rstw_idle", 64'(a_over), 64'h1);
        a_valid = 1'b0;
        step();

        // 64-bit bus: word loads, byte store, dword load
        b_valid = 1'b1; b_op = OP_LW; b_addr = 32'h0C; b_rdata = 64'h8000000100000000;
        b_ack = 1'b1; b_allow = 1'b1;
        step();
        chk("lw64_req",  64'(b_req),    64'h1);
        chk("lw64_addr", 64'(b_dmaddr), 64'h08);
        chk("lw64_wen",  64'(b_wen),    64'h0);
        step();
        chk("lw64_over",   64'(b_over), 64'h1);
        chk("lw64_result", b_res,       64'hFFFFFFFF80000001);
        step();
        b_op = OP_LWU;
        step(); step();
        chk("lwu64_result", b_res, 64'h0000000080000001);
        step();
        b_op = OP_SB; b_addr = 32'h0D; b_sdata = 64'hAB;
        step();
        chk("sb64_wen",   64'(b_wen), 64'h20);
        chk("sb64_wdata", b_wdata,    64'h0000AB0000000000);
        step(); step();
        b_op = OP_LD; b_addr = 32'h10; b_rdata = 64'h8123456789ABCDEF;
        step(); step();
        chk("ld64_result", b_res,       64'h8123456789ABCDEF);
        chk("ld64_over",   64'(b_over), 64'h1);
        step();
        b_op = OP_LD; b_addr = 32'h14;
        #1;
        chk("ld64_mis_adel", 64'(b_adel), 64'h1);
        chk("ld64_mis_over", 64'(b_over), 64'h1);
        b_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
